// File: rtl/instruction_loader.sv
// Boot-time loader: assembles a checksummed little-endian byte stream into 32-bit
// words, writes them to instruction memory, and releases the core only on success.
module instruction_loader #(
   parameter logic [63:0] BASE_ADDR = 64'd0,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        start,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        imem_we,
   output logic [63:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   // state | meaning
   // IDLE  | after reset, waiting for start
   // HDR0  | expecting word count low byte
   // HDR1  | expecting word count high byte
   // LOAD  | receiving payload bytes, writing words
   // CHK   | expecting checksum byte
   // DONE  | image verified, core released
   // ERR   | load failed, core held in reset
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR0 = 3'd1,
      HDR1 = 3'd2,
      LOAD = 3'd3,
      CHK  = 3'd4,
      DONE = 3'd5,
      ERR  = 3'd6
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] n_q, n_d;
   logic [23:0] word_q, word_d;
   logic [1:0]  idx_q, idx_d;
   logic [7:0]  csum_q, csum_d;
   logic [15:0] words_q, words_d;
   logic        we_q, we_d;
   logic [63:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        cpu_reset_q, cpu_reset_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        hs;
   logic [15:0] hdr_n;

   always_comb begin
      rx_ready = (state_q == HDR0) || (state_q == HDR1) ||
                 (state_q == LOAD) || (state_q == CHK);
   end

   assign hs    = rx_valid & rx_ready;
   assign hdr_n = {rx_data, n_q[7:0]};

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      word_d      = word_q;
      idx_d       = idx_q;
      csum_d      = csum_q;
      words_d     = words_q;
      we_d        = 1'b0;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cpu_reset_d = cpu_reset_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d     = HDR0;
               busy_d      = 1'b1;
               cpu_reset_d = 1'b1;
               done_d      = 1'b0;
               error_d     = 1'b0;
               words_d     = 16'd0;
               csum_d      = 8'd0;
               idx_d       = 2'd0;
            end
         end
         HDR0: begin
            if (hs) begin
               n_d[7:0] = rx_data;
               state_d  = HDR1;
            end
         end
         HDR1: begin
            if (hs) begin
               n_d[15:8] = rx_data;
               if ({16'd0, hdr_n} > MAX_WORDS) begin
                  state_d = ERR;
                  error_d = 1'b1;
                  busy_d  = 1'b0;
               end else if (hdr_n == 16'd0) begin
                  state_d = CHK;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (hs) begin
               csum_d = csum_q + rx_data;
               idx_d  = idx_q + 2'd1;
               case (idx_q)
                  2'd0: word_d[7:0]   = rx_data;
                  2'd1: word_d[15:8]  = rx_data;
                  2'd2: word_d[23:16] = rx_data;
                  default: begin
                     // Fourth byte bypasses the buffer straight into the write data.
                     we_d    = 1'b1;
                     wdata_d = {rx_data, word_q};
                     addr_d  = BASE_ADDR + {46'd0, words_q, 2'b00};
                     words_d = words_q + 16'd1;
                     if (words_q + 16'd1 == n_q) state_d = CHK;
                  end
               endcase
            end
         end
         CHK: begin
            if (hs) begin
               busy_d = 1'b0;
               if (rx_data == csum_q) begin
                  state_d     = DONE;
                  done_d      = 1'b1;
                  cpu_reset_d = 1'b0;
               end else begin
                  state_d = ERR;
                  error_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q     <= IDLE;
         n_q         <= 16'd0;
         word_q      <= 24'd0;
         idx_q       <= 2'd0;
         csum_q      <= 8'd0;
         words_q     <= 16'd0;
         we_q        <= 1'b0;
         addr_q      <= BASE_ADDR;
         wdata_q     <= 32'd0;
         cpu_reset_q <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         word_q      <= word_d;
         idx_q       <= idx_d;
         csum_q      <= csum_d;
         words_q     <= words_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cpu_reset_q <= cpu_reset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign imem_we      = we_q;
   assign imem_addr    = addr_q;
   assign imem_wdata   = wdata_q;
   assign cpu_reset    = cpu_reset_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader: directed and random frames against
// a frame-level reference model (expected write list, checksum, final status).
module tb_instruction_loader;

   localparam int MAXW = 1024;

   logic        CLOCK = 1'b0;
   logic        RESET;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [63:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   int checks = 0;
   int errors = 0;

   logic [95:0] exp_wr[$];
   logic [31:0] frame_words[$];

   instruction_loader #(.BASE_ADDR(64'd0), .MAX_WORDS(MAXW)) dut (
      .CLOCK(CLOCK), .RESET(RESET), .start(start), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
      .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge CLOCK) begin
      if (imem_we) begin
         if (exp_wr.size() == 0) begin
            chk("unexpected_we", 64'd1, 64'd0);
         end else begin
            logic [95:0] e;
            e = exp_wr.pop_front();
            chk("waddr", imem_addr, e[95:32]);
            chk("wdata", {32'd0, imem_wdata}, {32'd0, e[31:0]});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      for (int g = 0; g < gap; g++) begin
         rx_valid = 1'b0;
         @(negedge CLOCK);
      end
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge CLOCK);
      rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge CLOCK);
      start = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_cpu_reset"}, {63'd0, cpu_reset}, 64'd1);
      chk({tag, "_rx_ready"},  {63'd0, rx_ready},  64'd0);
      chk({tag, "_done"},      {63'd0, done},      64'd0);
      chk({tag, "_error"},     {63'd0, error},     64'd0);
      chk({tag, "_busy"},      {63'd0, busy},      64'd0);
      chk({tag, "_we"},        {63'd0, imem_we},   64'd0);
      chk({tag, "_addr"},      imem_addr,          64'd0);
      chk({tag, "_wdata"},     {32'd0, imem_wdata}, 64'd0);
      chk({tag, "_words"},     {48'd0, words_loaded}, 64'd0);
   endtask

   // Streams one frame built from frame_words (count n may differ for oversize tests).
   task automatic run_frame(input string tag, input int n, input logic bad_cs, input int gap_max);
      logic [7:0] cs;
      logic       ok;
      cs = 8'd0;
      pulse_start();
      chk({tag, "_busy_start"},  {63'd0, busy},      64'd1);
      chk({tag, "_ready_start"}, {63'd0, rx_ready},  64'd1);
      chk({tag, "_err_start"},   {63'd0, error},     64'd0);
      chk({tag, "_done_start"},  {63'd0, done},      64'd0);
      chk({tag, "_words_start"}, {48'd0, words_loaded}, 64'd0);
      send_byte(n[7:0], $urandom_range(0, gap_max));
      send_byte(n[15:8], $urandom_range(0, gap_max));
      if (n > MAXW) begin
         chk({tag, "_oversize_err"},  {63'd0, error},     64'd1);
         chk({tag, "_oversize_rst"},  {63'd0, cpu_reset}, 64'd1);
         chk({tag, "_oversize_rdy"},  {63'd0, rx_ready},  64'd0);
         chk({tag, "_oversize_busy"}, {63'd0, busy},      64'd0);
         send_byte(8'h55, 0);
         chk({tag, "_oversize_nowr"}, {32'd0, exp_wr.size()}, 64'd0);
         return;
      end
      for (int w = 0; w < n; w++) begin
         exp_wr.push_back({64'd0 + 64'(4 * w), frame_words[w]});
         for (int k = 0; k < 4; k++) begin
            logic [31:0] wv;
            wv = frame_words[w];
            cs = cs + wv[8*k +: 8];
            send_byte(wv[8*k +: 8], $urandom_range(0, gap_max));
         end
      end
      ok = !bad_cs;
      send_byte(bad_cs ? cs + 8'd1 : cs, $urandom_range(0, gap_max));
      chk({tag, "_done"},      {63'd0, done},      {63'd0, ok});
      chk({tag, "_error"},     {63'd0, error},     {63'd0, !ok});
      chk({tag, "_cpu_reset"}, {63'd0, cpu_reset}, {63'd0, !ok});
      chk({tag, "_busy_end"},  {63'd0, busy},      64'd0);
      chk({tag, "_rdy_end"},   {63'd0, rx_ready},  64'd0);
      chk({tag, "_words"},     {48'd0, words_loaded}, 64'(n));
      chk({tag, "_pending"},   {32'd0, exp_wr.size()}, 64'd0);
      repeat (3) @(negedge CLOCK);
      chk({tag, "_hold_done"}, {63'd0, done}, {63'd0, ok});
   endtask

   initial begin
      RESET = 1'b1; start = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
      repeat (3) @(negedge CLOCK);
      RESET = 1'b0;
      @(negedge CLOCK);
      check_reset_values("reset");

      frame_words = '{32'hF800_0000};
      run_frame("single", 1, 1'b0, 0);

      frame_words = '{32'h8B02_0020, 32'hCB01_0000};
      run_frame("two_gap", 2, 1'b0, 3);

      frame_words = '{32'hF800_0000};
      run_frame("badcs", 1, 1'b1, 0);
      frame_words = '{32'h1234_5678};
      run_frame("after_err", 1, 1'b0, 1);

      run_frame("oversize", 1025, 1'b0, 0);
      frame_words = {};
      run_frame("empty", 0, 1'b0, 0);

      // Mid-load: ignored start, then reset after 6 payload bytes.
      frame_words = '{32'hAABB_CCDD, 32'h1122_3344, 32'h5566_7788};
      pulse_start();
      send_byte(8'd3, 0);
      send_byte(8'd0, 0);
      exp_wr.push_back({64'd0, frame_words[0]});
      for (int k = 0; k < 4; k++) begin
         logic [31:0] wv;
         wv = frame_words[0];
         send_byte(wv[8*k +: 8], 0);
      end
      pulse_start();
      chk("ign_start_busy",  {63'd0, busy}, 64'd1);
      chk("ign_start_words", {48'd0, words_loaded}, 64'd1);
      send_byte(8'h44, 0);
      send_byte(8'h33, 0);
      RESET = 1'b1;
      @(negedge CLOCK);
      RESET = 1'b0;
      chk("midrst_pending", {32'd0, exp_wr.size()}, 64'd0);
      exp_wr = {};
      check_reset_values("midrst");
      frame_words = '{32'h0BAD_F00D, 32'hDEAD_BEEF};
      run_frame("post_rst", 2, 1'b0, 0);

      for (int t = 0; t < 12; t++) begin
         int n;
         n = $urandom_range(1, 12);
         frame_words = {};
         for (int w = 0; w < n; w++) frame_words.push_back($urandom);
         run_frame("rand", n, ($urandom_range(0, 3) == 0), 2);
      end

      frame_words = {};
      for (int w = 0; w < MAXW; w++) frame_words.push_back($urandom);
      run_frame("maxw", MAXW, 1'b0, 0);

      repeat (2) @(negedge CLOCK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Boot-time program loader that sits upstream of the pipelined LEGv8 core's instruction memory. It receives a byte stream with a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them through the instruction memory's write port. It holds the core in reset until a complete, checksum-verified image is written. On a failed load the core stays in reset and an error flag is raised.

Parameters:
BASE_ADDR, 64'd0, byte address of the first written instruction word
MAX_WORDS, 1024, largest accepted word count; a larger count is an error

Ports:
CLOCK  in  1  single clock; all state changes on rising edge
RESET  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; starts a load from IDLE, DONE or ERROR
rx_data  in  8  stream byte
rx_valid  in  1  rx_data is valid
rx_ready  out  1  loader accepts a byte; transfer occurs when rx_valid & rx_ready at the clock edge
imem_we  out  1  instruction memory write strobe, one cycle per word
imem_addr  out  64  byte address of the word being written
imem_wdata  out  32  instruction word being written
cpu_reset  out  1  holds the core (PC and pipeline registers) in reset while high
busy  out  1  a load is in progress
done  out  1  image loaded and verified
error  out  1  load failed (sticky)
words_loaded  out  16  count of words written in the current load

Behaviour:
- Reset and clock: one clock, CLOCK. Reset is synchronous and active-high, on RESET.
- Reset values: state=IDLE, rx_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_reset=1, busy=0, done=0, error=0, words_loaded=0, internal checksum=0, byte index=0.
- RESET has priority over all other inputs. If RESET is asserted mid-load, the load is abandoned and the block returns to the reset values on that edge.
- Frame format: HDR0 and HDR1 carry word count N (16 bits, little-endian). Then 4N payload bytes, each word least-significant byte first. Then one checksum byte, equal to the sum mod 256 of the payload bytes only.
- State machine: IDLE -> HDR0 -> HDR1 -> LOAD -> CHK -> DONE or ERROR.
  - IDLE: rx_ready=0. On start: go to HDR0; set busy=1, cpu_reset=1, done=0, error=0; clear words_loaded, checksum and byte index.
  - HDR0: on handshake, latch N[7:0].
  - HDR1: on handshake, latch N[15:8], then:
    - N > MAX_WORDS -> ERROR.
    - N == 0 -> CHK.
    - Otherwise -> LOAD.
  - LOAD: each accepted byte goes into lane byte_index[1:0] of the word buffer and is added to the checksum mod 256.
    - On the 4th byte of a word, the next edge registers: imem_we=1, imem_wdata=assembled word, imem_addr=BASE_ADDR + 4*words_loaded (pre-increment value).
    - words_loaded increments on that same edge.
    - imem_we is low on every other cycle.
    - When words_loaded reaches N, go to CHK.
    - rx_ready stays high; there is no back-pressure, and a byte may be accepted in the same cycle imem_we is high.
  - CHK: on handshake:
    - If the byte equals the checksum -> DONE: done=1, busy=0, cpu_reset=0 on that edge.
    - Otherwise -> ERROR: error=1, busy=0, cpu_reset stays 1.
  - DONE / ERROR: rx_ready=0. Outputs hold until start (restart, as from IDLE) or RESET.
- start in any other state (HDR0, HDR1, LOAD, CHK) is ignored.
- Cycles with rx_valid=0 leave all state unchanged. Gaps between bytes are unlimited, and there is no timeout.
- rx_ready=1 only in HDR0, HDR1, LOAD and CHK.
- Widths:
  - imem_addr is computed in 64 bits; wrap above 2^64 is not checked.
  - words_loaded is 16 bits and never exceeds MAX_WORDS.
  - The checksum is 8 bits and wraps.

Test Plan:
- Reset: assert RESET, then release -> cpu_reset=1, rx_ready=0, done=0, error=0, imem_we=0, imem_addr=BASE_ADDR.
- Single word: start, then stream 01 00 00 00 00 F8 F8 -> exactly one imem_we pulse with addr=0x0, wdata=0xF8000000, on the edge after the 4th payload byte. After the F8 checksum byte: done=1, cpu_reset=0, words_loaded=1.
- Two words with idle gaps: stream 02 00 20 00 02 8B 00 00 01 CB 79, with rx_valid dropped for 3 cycles between several bytes -> writes (0x0, 0x8B020020) then (0x4, 0xCB010000); done=1. Checksum 0xAD+0xCC=0x179, giving 0x79.
- Bad checksum: the single-word stream with trailer 0xF7 -> imem_we pulsed once, then error=1, done=0, cpu_reset stays 1, rx_ready=0. A following start clears error and accepts a new frame.
- Oversize and empty images:
  - Header 01 04 (N=1025) with MAX_WORDS=1024 -> ERROR immediately after HDR1, no imem_we.
  - Header 00 00 followed by checksum 00 -> DONE, words_loaded=0.
- Mid-load reset and ignored start: pulse start during LOAD -> no effect. Assert RESET after 6 payload bytes -> all outputs return to reset values, and a new load writes from addr 0x0.
